tdc_meas_ctrl: RTL and testbench
================================

// Module: tdc_meas_ctrl
// PURPOSE
//  Sequencer for one TDC measurement: launches a test pulse into the carry-chain pulse/one-shot path,
//  counts coarse clock cycles from start to stop and encodes the fine carry-chain thermometer snapshots.
//  Sits between the delay-line datapath (start/stop flags plus tap snapshots, registered on CLK12MHZ) and the readout logic.
//  Returns {coarse, fine_start, fine_stop, timeout} over a valid/ready handshake.
// PARAMETERS
//  TAPS     128   carry-chain taps per snapshot (4 per CARRY4)
//  COARSE_W 16    coarse counter width; must satisfy TIMEOUT < 2**COARSE_W
//  TIMEOUT  4095  max cycles waiting for start_hit, and separately for stop_hit
//  FINE_W   $clog2(TAPS+1)  encoded fine width (derived, localparam)
// PORTS
//  CLK12MHZ     in   1        system clock; all logic on posedge
//  en           in   1        synchronous active-low reset (0 = reset)
//  arm          in   1        request one measurement; sampled only in IDLE
//  fire         out  1        one-cycle launch strobe to the pulse generator
//  busy         out  1        1 in every state except IDLE
//  start_hit    in   1        registered start edge flag from datapath
//  stop_hit     in   1        registered stop edge flag from datapath
//  fine_start   in   TAPS     thermometer snapshot valid in the start_hit cycle
//  fine_stop    in   TAPS     thermometer snapshot valid in the stop_hit cycle
//  res_valid    out  1        result available; held until accepted
//  res_ready    in   1        consumer accepts when res_valid & res_ready
//  res_coarse   out  COARSE_W cycles from start_hit cycle to stop_hit cycle
//  res_fine_start out FINE_W  popcount of fine_start
//  res_fine_stop  out FINE_W  popcount of fine_stop
//  res_timeout  out  1        measurement aborted by TIMEOUT
// BEHAVIOUR
//  Reset (en=0 at a clock edge): state IDLE; every output 0; counters 0. Reset mid-measurement aborts with no result.
//  FSM: IDLE -arm-> LAUNCH (fire=1, 1 cycle) -> WAIT_START -start_hit-> COUNT -stop_hit-> ENCODE -> DONE -handshake-> IDLE.
//  WAIT_START: stop_hit without start_hit ignored. start_hit & stop_hit in same cycle -> coarse=0, both
//   snapshots captured, go directly to ENCODE.
//  COUNT: coarse increments each cycle; start_hit at cycle S, stop_hit at cycle N -> res_coarse = N-S.
//  Timeout: wait counter reaches TIMEOUT in WAIT_START or COUNT -> ENCODE with res_timeout=1,
//   res_coarse=TIMEOUT, missing snapshot(s) encoded as 0.
//  Fine encode: popcount (bubble-tolerant), registered, 1 cycle. stop_hit at cycle N -> res_valid=1 at N+2.
//  DONE: res_* stable while res_valid=1 & res_ready=0; res_valid drops the cycle after acceptance.
//  arm outside IDLE ignored (not queued). res_ready outside DONE ignored.
//  Snapshot inputs sampled only in their flag cycle; otherwise ignored.
// CONFIGURATION
//  TDC_MEAS_CTRL_ERRCNT_EN defined: extra output err_cnt [7:0], +1 per timeout result accepted,
//   saturates at 255, cleared only by reset.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package tdc_pkg: state enum (IDLE, LAUNCH, WAIT_START, COUNT, ENCODE, DONE), TDC_TAPS_DEF=128,
//   TDC_TIMEOUT_DEF=4095, fine_width() function.
//  Sub-module tdc_therm_enc: registered TAPS-bit popcount, FINE_W output; two instances (start, stop).
// TESTING
//  1 arm=1 in IDLE -> fire high exactly 1 cycle next cycle, busy=1 until handshake.
//  2 start_hit at S, stop_hit at S+37, fine_start=32 ones, fine_stop=90 ones -> res_coarse=37,
//    res_fine_start=32, res_fine_stop=90, res_timeout=0, res_valid at S+39.
//  3 start_hit & stop_hit same cycle, snapshots 5/7 ones -> res_coarse=0, fine 5/7.
//  4 no stop_hit after start -> after 4095 cycles res_timeout=1, res_coarse=4095, fine_stop=0;
//    with TDC_MEAS_CTRL_ERRCNT_EN err_cnt 0->1 on accept.
//  5 res_ready=0 for 10 cycles in DONE -> outputs stable; arm pulses ignored, no second fire.
//  6 en=0 during COUNT -> next cycle busy=0, res_valid=0, fire=0; fresh arm gives correct result.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
package tdc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      COUNT,
      ENCODE,
      DONE
   } state_t;

   localparam int TDC_TAPS_DEF    = 128;
   localparam int TDC_TIMEOUT_DEF = 4095;

   // Width needed to hold a popcount of 0..taps.
   function automatic int fine_width(input int taps);
      return $clog2(taps + 1);
   endfunction

endpackage

// File: rtl/tdc_therm_enc.sv
// Registered popcount of one carry-chain thermometer snapshot.
// Counting ones rather than finding the first zero makes the result
// tolerant of bubbles in the thermometer code.
module tdc_therm_enc
   import tdc_pkg::*;
#(
   parameter  int TAPS   = TDC_TAPS_DEF,
   localparam int FINE_W = fine_width(TAPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [TAPS-1:0]   therm,
   output logic [FINE_W-1:0] count
);

   logic [FINE_W-1:0] ones;

   // Population count of the snapshot.
   always_comb begin
      ones = '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
         ones = ones + FINE_W'(therm[i]);
      end
   end

   // Hold the encoded value; only the flag cycle loads, clear starts a new measurement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= ones;
      end
   end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequencer for one TDC measurement: fires the test pulse, counts coarse
// cycles between start and stop flags and encodes both fine snapshots.
// Optional: define TDC_MEAS_CTRL_ERRCNT_EN to add the saturating timeout
// counter output err_cnt.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter  int TAPS     = TDC_TAPS_DEF,
   parameter  int COARSE_W = 16,
   parameter  int TIMEOUT  = TDC_TIMEOUT_DEF,
   localparam int FINE_W   = fine_width(TAPS)
) (
   input  logic                CLK12MHZ,
   input  logic                en,
   input  logic                arm,
   output logic                fire,
   output logic                busy,
   input  logic                start_hit,
   input  logic                stop_hit,
   input  logic [TAPS-1:0]     fine_start,
   input  logic [TAPS-1:0]     fine_stop,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [COARSE_W-1:0] res_coarse,
   output logic [FINE_W-1:0]   res_fine_start,
   output logic [FINE_W-1:0]   res_fine_stop,
`ifdef TDC_MEAS_CTRL_ERRCNT_EN
   output logic [7:0]          err_cnt,
`endif
   output logic                res_timeout
);

   localparam logic [COARSE_W-1:0] TMO = COARSE_W'(TIMEOUT);

   state_t              state;
   state_t              state_nxt;
   logic [COARSE_W-1:0] cnt;
   logic                ld_start;
   logic                ld_stop;
   logic                clr_enc;
   logic                tmo;

   // State register.
   always_ff @(posedge CLK12MHZ) begin
      if (!en) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and control strobes.
   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      busy      = 1'b1;
      res_valid = 1'b0;
      ld_start  = 1'b0;
      ld_stop   = 1'b0;
      clr_enc   = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (arm) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            fire      = 1'b1;
            clr_enc   = 1'b1;
            state_nxt = WAIT_START;
         end
         WAIT_START: begin
            if (start_hit) begin
               ld_start = 1'b1;
               if (stop_hit) begin
                  ld_stop   = 1'b1;
                  state_nxt = ENCODE;
               end else begin
                  state_nxt = COUNT;
               end
            end else if (cnt == TMO) begin
               tmo       = 1'b1;
               state_nxt = ENCODE;
            end
         end
         COUNT: begin
            if (stop_hit) begin
               ld_stop   = 1'b1;
               state_nxt = ENCODE;
            end else if (cnt == TMO) begin
               tmo       = 1'b1;
               state_nxt = ENCODE;
            end
         end
         ENCODE: begin
            state_nxt = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Wait/coarse counter and result capture. cnt holds the number of cycles
   // spent in the current wait state, so in COUNT it equals N-S directly.
   always_ff @(posedge CLK12MHZ) begin
      if (!en) begin
         cnt         <= '0;
         res_coarse  <= '0;
         res_timeout <= 1'b0;
      end else begin
         case (state)
            LAUNCH: begin
               cnt         <= COARSE_W'(1);
               res_coarse  <= '0;
               res_timeout <= 1'b0;
            end
            WAIT_START: begin
               cnt <= start_hit ? COARSE_W'(1) : cnt + COARSE_W'(1);
               if (tmo) begin
                  res_coarse  <= TMO;
                  res_timeout <= 1'b1;
               end
            end
            COUNT: begin
               cnt <= cnt + COARSE_W'(1);
               if (ld_stop) begin
                  res_coarse <= cnt;
               end else if (tmo) begin
                  res_coarse  <= TMO;
                  res_timeout <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef TDC_MEAS_CTRL_ERRCNT_EN
   // Saturating count of accepted timeout results.
   always_ff @(posedge CLK12MHZ) begin
      if (!en) begin
         err_cnt <= '0;
      end else if (state == DONE && res_ready && res_timeout && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

   tdc_therm_enc #(.TAPS(TAPS)) u_enc_start (
      .clk   (CLK12MHZ),
      .rst_n (en),
      .clr   (clr_enc),
      .load  (ld_start),
      .therm (fine_start),
      .count (res_fine_start)
   );

   tdc_therm_enc #(.TAPS(TAPS)) u_enc_stop (
      .clk   (CLK12MHZ),
      .rst_n (en),
      .clr   (clr_enc),
      .load  (ld_stop),
      .therm (fine_stop),
      .count (res_fine_stop)
   );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed, table-driven bench for tdc_meas_ctrl.
module tb_tdc_meas_ctrl;

   localparam int TAPS    = 128;
   localparam int TIMEOUT = 4095;

   logic         clk = 1'b0;
   logic         en;
   logic         arm;
   logic         fire;
   logic         busy;
   logic         start_hit;
   logic         stop_hit;
   logic [127:0] fine_start;
   logic [127:0] fine_stop;
   logic         res_valid;
   logic         res_ready;
   logic [15:0]  res_coarse;
   logic [7:0]   res_fine_start;
   logic [7:0]   res_fine_stop;
   logic         res_timeout;
`ifdef TDC_MEAS_CTRL_ERRCNT_EN
   logic [7:0]   err_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int err_exp = 0;

   tdc_meas_ctrl #(.TAPS(TAPS), .COARSE_W(16), .TIMEOUT(TIMEOUT)) dut (
      .CLK12MHZ       (clk),
      .en             (en),
      .arm            (arm),
      .fire           (fire),
      .busy           (busy),
      .start_hit      (start_hit),
      .stop_hit       (stop_hit),
      .fine_start     (fine_start),
      .fine_stop      (fine_stop),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_coarse     (res_coarse),
      .res_fine_start (res_fine_start),
      .res_fine_stop  (res_fine_stop),
`ifdef TDC_MEAS_CTRL_ERRCNT_EN
      .err_cnt        (err_cnt),
`endif
      .res_timeout    (res_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int start_dly;
      int stop_dly;
      bit no_start;
      bit no_stop;
      bit stray_stop;
      bit ready_early;
      int hold;
      int n_fs;
      int n_fp;
      int exp_coarse;
      int exp_fs;
      int exp_fp;
      bit exp_to;
      int exp_lat;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Thermometer of n ones with one bubble (bit n-2 cleared, bit n set).
   function automatic logic [127:0] therm(input int n);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      if (n > 1 && n < 128) begin
         t[n-2] = 1'b0;
         t[n]   = 1'b1;
      end
      return t;
   endfunction

   task automatic chk_err_cnt();
`ifdef TDC_MEAS_CTRL_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(err_exp));
`endif
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  ref_cyc;
      bit  got;
      string tag;
      tag = $sformatf("v%0d", idx);
      res_ready = v.ready_early;
      @(negedge clk) arm = 1'b1;
      @(negedge clk) arm = 1'b0;
      chk({tag, " fire_hi"}, 32'(fire), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      ref_cyc = cyc;
      @(negedge clk);
      chk({tag, " fire_lo"}, 32'(fire), 32'd0);
      if (!v.no_start) begin
         repeat (v.start_dly) begin
            stop_hit = v.stray_stop;
            @(negedge clk);
         end
         stop_hit   = 1'b0;
         start_hit  = 1'b1;
         fine_start = therm(v.n_fs);
         if (!v.no_stop && v.stop_dly == 0) begin
            stop_hit  = 1'b1;
            fine_stop = therm(v.n_fp);
         end
         ref_cyc = cyc;
         @(negedge clk);
         start_hit  = 1'b0;
         stop_hit   = 1'b0;
         fine_start = '1;
         fine_stop  = '1;
         if (!v.no_stop && v.stop_dly > 0) begin
            repeat (v.stop_dly - 1) @(negedge clk);
            stop_hit  = 1'b1;
            fine_stop = therm(v.n_fp);
            @(negedge clk);
            stop_hit  = 1'b0;
            fine_stop = '1;
         end
      end
      got = 1'b0;
      for (int i = 0; i < TIMEOUT + 50 && !got; i++) begin
         if (res_valid === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      chk({tag, " valid_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(cyc - ref_cyc), 32'(v.exp_lat));
      chk({tag, " coarse"}, 32'(res_coarse), 32'(v.exp_coarse));
      chk({tag, " fine_start"}, 32'(res_fine_start), 32'(v.exp_fs));
      chk({tag, " fine_stop"}, 32'(res_fine_stop), 32'(v.exp_fp));
      chk({tag, " timeout"}, 32'(res_timeout), 32'(v.exp_to));
      for (int h = 0; h < v.hold; h++) begin
         res_ready = 1'b0;
         arm = h[0];
         @(negedge clk);
         chk({tag, " hold_valid"}, 32'(res_valid), 32'd1);
         chk({tag, " hold_fire"}, 32'(fire), 32'd0);
         chk({tag, " hold_coarse"}, 32'(res_coarse), 32'(v.exp_coarse));
         chk({tag, " hold_fs"}, 32'(res_fine_start), 32'(v.exp_fs));
         chk({tag, " hold_fp"}, 32'(res_fine_stop), 32'(v.exp_fp));
         chk({tag, " hold_to"}, 32'(res_timeout), 32'(v.exp_to));
      end
      arm = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, " valid_drop"}, 32'(res_valid), 32'd0);
      chk({tag, " idle"}, 32'(busy), 32'd0);
      if (v.exp_to && err_exp < 255) err_exp++;
      chk_err_cnt();
      @(negedge clk);
      chk({tag, " no_refire"}, 32'(fire), 32'd0);
      chk({tag, " still_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " fire"}, 32'(fire), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " valid"}, 32'(res_valid), 32'd0);
      chk({tag, " coarse"}, 32'(res_coarse), 32'd0);
      chk({tag, " fs"}, 32'(res_fine_start), 32'd0);
      chk({tag, " fp"}, 32'(res_fine_stop), 32'd0);
      chk({tag, " to"}, 32'(res_timeout), 32'd0);
      chk_err_cnt();
   endtask

   initial begin
      //           sdly pdly nst nsp stray rdy hold fs  fp  coarse fs  fp  to lat
      vecs[0] = '{3,   37,  0,  0,  0,    0,  10,  32, 90, 37,    32, 90, 0, 39};
      vecs[1] = '{0,   0,   0,  0,  0,    0,  0,   5,  7,  0,     5,  7,  0, 2};
      vecs[2] = '{4,   1,   0,  0,  1,    0,  0,   0,  3,  1,     0,  3,  0, 3};
      vecs[3] = '{1,   200, 0,  0,  0,    1,  0,   128, 1, 200,   128, 1, 0, 202};
      vecs[4] = '{2,   0,   0,  1,  0,    0,  3,   17, 0,  4095,  17, 0,  1, 4097};
      vecs[5] = '{0,   0,   1,  0,  0,    0,  0,   0,  0,  4095,  0,  0,  1, 4097};
      vecs[6] = '{0,   4095,0,  0,  0,    0,  0,   64, 64, 4095,  64, 64, 0, 4097};

      en = 1'b0;
      arm = 1'b0;
      start_hit = 1'b0;
      stop_hit = 1'b0;
      fine_start = '1;
      fine_stop = '1;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      en = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

      // Reset in the middle of COUNT aborts without a result.
      @(negedge clk) arm = 1'b1;
      @(negedge clk) arm = 1'b0;
      @(negedge clk);
      start_hit = 1'b1;
      fine_start = therm(20);
      @(negedge clk);
      start_hit = 1'b0;
      fine_start = '1;
      repeat (10) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      en = 1'b0;
      err_exp = 0;
      @(negedge clk);
      chk_all_zero("mid_reset");
      en = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_valid", 32'(res_valid), 32'd0);
      run_vec(vecs[0], 10);
      run_vec(vecs[1], 11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
